// File: rtl/multiplier_iterative_param_if.sv
// multiplier_iterative_param_if: operand request and product handshake bundle
interface multiplier_iterative_param_if #(
  parameter int WIDTH = 32
);
  logic valid_in;
  logic signed_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready_in;
  logic valid_out;
  logic [2*WIDTH-1:0] r;
  modport master (output valid_in, signed_in, a, b, input ready_in, valid_out, r);
  modport slave (input valid_in, signed_in, a, b, output ready_in, valid_out, r);
endinterface

// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param: sign-magnitude shift-add multiplier, RADIX_BITS per cycle, early exit
module multiplier_iterative_param #(
  parameter int WIDTH = 32,
  parameter int RADIX_BITS = 1
) (
  input logic clk,
  input logic rst_n,
  multiplier_iterative_param_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_nxt;
  logic [PW-1:0] digit;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] mplier_nxt;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic neg;
  logic accept;
  // negating the most-negative value wraps back to 2^(WIDTH-1), its correct magnitude
  always_comb begin
    mag_a = (bus.signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (bus.signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    digit = PW'(mplier[RADIX_BITS-1:0]);
    acc_nxt = acc + mcand * digit;
    mplier_nxt = mplier >> RADIX_BITS;
    accept = bus.valid_in && bus.ready_in;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.ready_in <= 1'b1;
      bus.valid_out <= 1'b0;
      bus.r <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
    end else if (accept) begin
      state <= BUSY;
      bus.ready_in <= 1'b0;
      bus.valid_out <= 1'b0;
      acc <= '0;
      mcand <= PW'(mag_a);
      mplier <= mag_b;
      neg <= bus.signed_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    end else if (state == BUSY) begin
      acc <= acc_nxt;
      mcand <= mcand << RADIX_BITS;
      mplier <= mplier_nxt;
      if (mplier_nxt == '0) begin
        state <= DONE;
        bus.ready_in <= 1'b1;
        bus.valid_out <= 1'b1;
        bus.r <= neg ? -acc_nxt : acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_multiplier_iterative_param.sv
// tb_multiplier_iterative_param: directed, handshake, reset and random scoreboard checks
module tb_multiplier_iterative_param;
  logic clk;
  logic rst_n;
  logic d_valid, d_signed, use4, rand_go;
  logic [31:0] d_a, d_b;
  logic mo_ready, mo_valid;
  logic [63:0] mo_r;
  logic [63:0] exp_q [$];
  logic [63:0] last_exp [2];
  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multiplier_iterative_param_if #(.WIDTH(32)) bus1 ();
  multiplier_iterative_param_if #(.WIDTH(32)) bus4 ();
  multiplier_iterative_param #(.WIDTH(32), .RADIX_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  multiplier_iterative_param #(.WIDTH(32), .RADIX_BITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus1.valid_in = d_valid && !use4;
  assign bus4.valid_in = d_valid && use4;
  assign bus1.signed_in = d_signed;
  assign bus4.signed_in = d_signed;
  assign bus1.a = d_a;
  assign bus4.a = d_a;
  assign bus1.b = d_b;
  assign bus4.b = d_b;
  assign mo_ready = use4 ? bus4.ready_in : bus1.ready_in;
  assign mo_valid = use4 ? bus4.valid_out : bus1.valid_out;
  assign mo_r = use4 ? bus4.r : bus1.r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] mask2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
    logic [63:0] xa = {32'd0, a} & mask;
    logic [63:0] xb = {32'd0, b} & mask;
    if (s && xa[w-1]) xa = xa | ~mask;
    if (s && xb[w-1]) xb = xb | ~mask;
    return (xa * xb) & mask2;
  endfunction

  function automatic int exp_n(input int w, input int rdx, input logic s, input logic [31:0] b);
    logic [31:0] mask = (w == 32) ? '1 : (32'd1 << w) - 32'd1;
    logic [31:0] m = b & mask;
    int p = -1;
    if (s && m[w-1]) m = (-m) & mask;
    for (int i = 0; i < w; i++) if (m[i]) p = i;
    return (p < 0) ? 1 : (p + rdx) / rdx;
  endfunction

  task automatic do_op(input logic u4, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] er, input int en, input string tag);
    int cnt;
    @(negedge clk);
    use4 = u4;
    d_signed = s;
    d_a = a;
    d_b = b;
    d_valid = 1'b1;
    check({tag, "_rdy"}, 64'(mo_ready), 64'd1);
    exp_q.push_back(er);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    d_a = ~a;
    d_b = ~b;
    d_signed = ~s;
    check({tag, "_busy"}, {62'd0, mo_ready, mo_valid}, 64'd0);
    check({tag, "_hold"}, mo_r, last_exp[u4]);
    cnt = 0;
    while (!mo_valid && cnt < 80) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(en));
    check({tag, "_r"}, mo_r, exp_q.pop_front());
    last_exp[u4] = er;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_stable"}, {mo_r[62:0], mo_valid}, {er[62:0], 1'b1});
  endtask

  for (genvar g = 0; g < 6; g++) begin : gen_rand
    localparam int W = (g < 3) ? 16 : 32;
    localparam int R = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;
    multiplier_iterative_param_if #(.WIDTH(W)) bus ();
    multiplier_iterative_param #(.WIDTH(W), .RADIX_BITS(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    logic [63:0] q [$];
    initial begin
      logic [31:0] ra, rb;
      logic rs;
      int cnt;
      bus.valid_in = 1'b0;
      bus.signed_in = 1'b0;
      bus.a = '0;
      bus.b = '0;
      wait (rand_go);
      for (int i = 0; i < 200; i++) begin
        ra = $urandom();
        rb = $urandom();
        rs = 1'($urandom_range(0, 1));
        case (i % 8)
          1: rb = '0;
          2: rb = '1;
          3: begin
            ra = 32'd1 << (W - 1);
            rb = ra;
          end
          4: rb = 32'($urandom_range(0, 15));
          default: ;
        endcase
        @(negedge clk);
        bus.a = ra[W-1:0];
        bus.b = rb[W-1:0];
        bus.signed_in = rs;
        bus.valid_in = 1'b1;
        q.push_back(ref_mul(W, rs, ra, rb));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.a = ~bus.a;
        bus.b = ~bus.b;
        cnt = 0;
        while (!bus.valid_out && cnt < 80) begin
          @(posedge clk);
          #1;
          cnt++;
        end
        check($sformatf("rand_w%0d_r%0d_lat", W, R), 64'(cnt), 64'(exp_n(W, R, rs, rb)));
        check($sformatf("rand_w%0d_r%0d_r", W, R), 64'(bus.r), q.pop_front());
      end
      n_done++;
    end
  end

  initial begin
    int k, done_cnt, cnt;
    rst_n = 1'b0;
    d_valid = 1'b0;
    d_signed = 1'b0;
    use4 = 1'b0;
    d_a = '0;
    d_b = '0;
    rand_go = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_p1", {mo_r[61:0], mo_ready, mo_valid}, 64'd2);
    check("rst_p4", {bus4.r[61:0], bus4.ready_in, bus4.valid_out}, 64'd2);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 1'b0, '1, '1, 64'hFFFFFFFE00000001, 32, "u_max");
    do_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 32, "s_minmin");
    do_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 64'd3, 1, "s_m3m1");
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 64'd0, 1, "u_b0");
    do_op(1'b1, 1'b1, 32'd7, 32'hFFFFFFFA, 64'hFFFFFFFFFFFFFFD6, 1, "r4_7m6");
    do_op(1'b1, 1'b0, 32'h12345678, 32'h00010000, 64'h0000123456780000, 5, "r4_b16");
    do_op(1'b1, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, 8, "r4_minmax");
    do_op(1'b1, 1'b0, '1, '1, 64'hFFFFFFFE00000001, 8, "r4_max");
    // valid_in held high: each DONE cycle must accept exactly one new request
    @(negedge clk);
    use4 = 1'b0;
    d_valid = 1'b1;
    k = 0;
    done_cnt = 0;
    for (int c = 0; c < 400 && !(k == 5 && exp_q.size() == 0); c++) begin
      if (c > 0) @(negedge clk);
      if (mo_valid && k > 0) begin
        check("hs_r", mo_r, exp_q.pop_front());
        done_cnt++;
      end
      if (mo_ready && k < 5) begin
        d_a = 32'(k * 1000 + 7);
        d_b = 32'(k * 3 + 1);
        d_signed = 1'b0;
        exp_q.push_back(ref_mul(32, 1'b0, d_a, d_b));
        k++;
      end else begin
        d_a = $urandom();
        d_b = $urandom();
        d_signed = 1'($urandom_range(0, 1));
        if (k == 5) d_valid = 1'b0;
      end
    end
    d_valid = 1'b0;
    check("hs_done", 64'(done_cnt), 64'd5);
    check("hs_q", 64'(exp_q.size()), 64'd0);
    last_exp[0] = 64'd4000 * 64'd13 + 64'd7 * 64'd13;
    do_op(1'b0, 1'b0, 32'd6, 32'd7, 64'd42, 3, "u_6x7");
    // abort a long operation with an asynchronous reset
    @(negedge clk);
    use4 = 1'b0;
    d_signed = 1'b0;
    d_a = 32'd3;
    d_b = 32'hFFFFFFFF;
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid", {mo_r[61:0], mo_ready, mo_valid}, 64'd2);
    last_exp[0] = '0;
    last_exp[1] = '0;
    @(negedge clk);
    d_a = 32'd6;
    d_b = 32'd7;
    d_valid = 1'b1;
    exp_q.push_back(64'd42);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    check("rst_first_acc", 64'(mo_ready), 64'd0);
    cnt = 0;
    while (!mo_valid && cnt < 80) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("rst_next_lat", 64'(cnt), 64'd3);
    check("rst_next_r", mo_r, exp_q.pop_front());
    rand_go = 1'b1;
    for (int c = 0; c < 30000 && n_done < 6; c++) @(posedge clk);
    check("rand_done", 64'(n_done), 64'd6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
